fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Round-robin push-side scheduler that shares one `cva6_fifo_v3` instance (non-fall-through, `DEPTH` entries) between `NUM_REQ` requesters. It tags each pushed word with the requester ID. It tracks per-requester occupancy against a quota so that no single requester can monopolise the queue. It also sequences drain and flush operations on the shared FIFO. The block sits between the requester valid/ready ports and the FIFO push/flush/status ports; the FIFO consumer pops independently and reports the popped ID back.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_WIDTH`, 32, payload width per requester
- `QUOTA`, 4, max entries one requester may hold in the FIFO (1..`DEPTH`)
- `IDW`, `$clog2(NUM_REQ)`, derived ID width (do not override)
- `CW`, `$clog2(QUOTA+1)`, derived counter width (do not override)

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  `NUM_REQ`  per-requester push request
- `req_data_i`  in  `NUM_REQ`×`DATA_WIDTH`  per-requester payload
- `req_ready_o`  out  `NUM_REQ`  one-hot grant; a push occurs when valid&ready
- `fifo_full_i`  in  1  FIFO `full_o`
- `fifo_empty_i`  in  1  FIFO `empty_o`
- `fifo_push_o`  out  1  FIFO `push_i`
- `fifo_data_o`  out  `IDW+DATA_WIDTH`  FIFO `data_i`, {id, payload}
- `fifo_flush_o`  out  1  FIFO `flush_i`
- `fifo_pop_i`  in  1  consumer pop strobe (FIFO `pop_i` & ~`empty_o`)
- `fifo_pop_id_i`  in  `IDW`  ID field of the popped entry
- `drain_req_i`  in  1  request to stop pushes until the FIFO is empty
- `drain_ack_o`  out  1  one-cycle pulse: drain complete
- `flush_req_i`  in  1  request to discard FIFO contents
- `flush_ack_o`  out  1  one-cycle pulse: flush performed
- `cnt_o`  out  `NUM_REQ`×`CW`  per-requester occupancy (debug/perf)

## Operation
- Registered state: `state_q` ∈ {RUN, DRAIN, FLUSH}, `rr_q` (`IDW` bits), `cnt_q[NUM_REQ]` (`CW` bits each).
- Eligibility: requester i is eligible when `req_valid_i[i]`, `cnt_q[i] < QUOTA`, `state_q == RUN` and `!fifo_full_i`.
- Arbitration: the winner is the first eligible index scanning `rr_q`, `rr_q+1`, … modulo `NUM_REQ`.
  - `req_ready_o` is one-hot on the winner, else all zero.
  - `fifo_push_o` = any winner.
  - `fifo_data_o` = {winner ID, winner payload}; it is 0 when there is no winner.
- `rr_q` is updated only on a push, to (winner+1) mod `NUM_REQ`; it wraps from `NUM_REQ-1` to 0.
- Counters:
  - `cnt_q[winner]` +1 on push.
  - `cnt_q[fifo_pop_id_i]` −1 on `fifo_pop_i`.
  - Push and pop on the same ID in the same cycle leaves the count unchanged.
  - A pop on a zero count is ignored (assertion error); an increment past `QUOTA` is impossible by eligibility.
- FSM transitions, evaluated in priority order:
  - Any state with `flush_req_i`=1 → FLUSH.
  - RUN with `drain_req_i`=1 → DRAIN.
  - DRAIN with `fifo_empty_i`=1 → RUN; `drain_ack_o`=1 in that cycle.
  - FLUSH with `flush_req_i`=0 → RUN.
- FLUSH state:
  - `fifo_flush_o`=1 and `flush_ack_o`=1 every FLUSH cycle.
  - No grants.
  - All `cnt_q` ← 0 and `rr_q` ← 0, with pops ignored.
- Flush requested while in DRAIN aborts the drain; no `drain_ack_o` is issued.
- DRAIN with `drain_req_i` already low still completes and acks.
- Reset values: `state_q`=RUN, `rr_q`=0, `cnt_q`=0.
  - With all `req_valid_i`=0, every output is 0: `req_ready_o`, `fifo_push_o`, `fifo_data_o`, `fifo_flush_o`, `drain_ack_o`, `flush_ack_o`, `cnt_o`.
  - Reset asserted mid-drain or mid-flush returns to RUN with no ack.

## Timing
- Grant is combinational from inputs and registered state: a request is accepted in the same cycle it is presented, when eligible.
- Pushed data is visible at the FIFO head no earlier than the next cycle (FIFO is non-fall-through).
- `fifo_full_i` and `cnt_q` are registered, so there is no combinational loop through the FIFO.
- `flush_req_i` sampled high at edge t → FLUSH during cycle t+1 (`fifo_flush_o`, `flush_ack_o` high) → RUN at t+2 if `flush_req_i` has dropped.
- `drain_req_i` at t → DRAIN from t+1 (no grants) → `drain_ack_o` in the first DRAIN cycle with `fifo_empty_i`=1 → grants resume the following cycle.
- Pop feedback updates `cnt_q` one cycle after `fifo_pop_i`; the freed quota slot is grantable in that next cycle.

## Test plan
- Round robin: `NUM_REQ`=4, all requesters valid, FIFO never full, consumer popping every cycle → grants 0,1,2,3,0,1…; each `fifo_data_o` ID matches its grant.
- Quota:
  - `QUOTA`=2, only requester 1 valid, no pops → exactly two pushes, then `req_ready_o[1]`=0 and `cnt_o[1]`=2.
  - One pop with ID 1 → push resumes on the next cycle.
- Full/simultaneous:
  - Fill the FIFO to `DEPTH`=8 → no grants while `fifo_full_i`.
  - Push and pop of the same ID in one cycle → that counter is unchanged.
- Drain: 3 entries queued, assert `drain_req_i` → no grants until empty; `drain_ack_o` is a single pulse in the cycle `fifo_empty_i` rises; round robin resumes from the stored `rr_q`.
- Flush:
  - Flush mid-DRAIN with 5 entries queued → one FLUSH cycle with `fifo_flush_o`=1; all counters and `rr_q` read 0 afterwards; no `drain_ack_o`.
  - Assert `rst_ni`=0 during FLUSH → all outputs 0 immediately.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Round-robin push-side scheduler in front of one shared, non-fall-through
// FIFO. Every pushed word is tagged with the requester ID. A per-requester
// occupancy count, capped at QUOTA, stops any single requester from filling
// the queue. The block also sequences drain (no pushes until the FIFO is
// empty) and flush (discard all contents) operations.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_valid_i         per-requester push request
//   req_data_i          per-requester payload
//   req_ready_o         one-hot grant; a push happens on valid & ready
//   fifo_full_i         FIFO full status (registered inside the FIFO)
//   fifo_empty_i        FIFO empty status
//   fifo_push_o         FIFO push strobe
//   fifo_data_o         FIFO write word, {id, payload}; zero when idle
//   fifo_flush_o        FIFO flush strobe
//   fifo_pop_i          consumer pop strobe (already qualified by !empty)
//   fifo_pop_id_i       ID field of the popped entry
//   drain_req_i         stop pushes until the FIFO is empty
//   drain_ack_o         one-cycle pulse when the drain completes
//   flush_req_i         discard FIFO contents
//   flush_ack_o         high in every cycle a flush is performed
//   cnt_o               per-requester occupancy counters
// ----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QUOTA      = 4,
  parameter int unsigned IDW        = $clog2(NUM_REQ),
  parameter int unsigned CW         = $clog2(QUOTA + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic                                fifo_full_i,
  input  logic                                fifo_empty_i,
  output logic                                fifo_push_o,
  output logic [IDW+DATA_WIDTH-1:0]           fifo_data_o,
  output logic                                fifo_flush_o,
  input  logic                                fifo_pop_i,
  input  logic [IDW-1:0]                      fifo_pop_id_i,
  input  logic                                drain_req_i,
  output logic                                drain_ack_o,
  input  logic                                flush_req_i,
  output logic                                flush_ack_o,
  output logic [NUM_REQ-1:0][CW-1:0]          cnt_o
);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_e;

  state_e                     state_q, state_d;
  logic [IDW-1:0]             rr_q, rr_d;
  logic [NUM_REQ-1:0][CW-1:0] cnt_q, cnt_d;

  logic                       run;
  logic [NUM_REQ-1:0]         elig;
  logic                       grant_vld;
  logic [IDW-1:0]             winner;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // Flush overrides everything, including an in-progress drain.
  always_comb begin
    state_d = state_q;
    if (flush_req_i) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        RUN:     if (drain_req_i)  state_d = DRAIN;
        DRAIN:   if (fifo_empty_i) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // The drain ack is suppressed when a flush pre-empts the DRAIN->RUN exit.
  always_comb begin
    run          = (state_q == RUN);
    fifo_flush_o = (state_q == FLUSH);
    flush_ack_o  = (state_q == FLUSH);
    drain_ack_o  = (state_q == DRAIN) && fifo_empty_i && !flush_req_i;
  end

  // ---------------- Eligibility and round-robin pick ----------------
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < CW'(QUOTA)) && run && !fifo_full_i;
    end
  end

  // Scan rr_q, rr_q+1, ... modulo NUM_REQ; the first eligible index wins.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] cand;
    grant_vld = 1'b0;
    winner    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        winner    = cand;
      end
    end
  end

  assign req_ready_o = grant_vld ? (NUM_REQ'(1) << winner) : '0;
  assign fifo_push_o = grant_vld;
  assign fifo_data_o = grant_vld ? {winner, req_data_i[winner]} : '0;
  assign cnt_o       = cnt_q;

  // ---------------- Pointer and occupancy next state ----------------
  always_comb begin
    rr_d = rr_q;
    if (state_q == FLUSH) begin
      rr_d = '0;
    end else if (grant_vld) begin
      rr_d = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Push and pop on the same ID cancel; a pop against a zero count is dropped.
  always_comb begin
    logic inc, dec;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inc = grant_vld && (winner == IDW'(i));
      dec = fifo_pop_i && (fifo_pop_id_i == IDW'(i)) && (cnt_q[i] != '0);
      if (state_q == FLUSH)  cnt_d[i] = '0;
      else if (inc && !dec)  cnt_d[i] = cnt_q[i] + 1'b1;
      else if (dec && !inc)  cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  // A pop reported for a requester that holds no entries means the consumer
  // and this block disagree about the FIFO contents.
  pop_on_zero_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fifo_pop_i && state_q != FLUSH) |-> (cnt_q[fifo_pop_id_i] != '0))
    else $error("pop reported for requester with zero occupancy");

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Directed bench for fifo_push_arbiter with NUM_REQ=4, QUOTA=2, DATA_WIDTH=16
// in front of a behavioural 8-deep FIFO that tracks the pushed IDs so the
// consumer pop ID always matches the real queue head. Inputs change 1 time
// unit after the rising edge; outputs are checked on the falling edge.
// ----------------------------------------------------------------------------
module tb_fifo_push_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 16;
  localparam int Q     = 2;
  localparam int IDW   = 2;
  localparam int CW    = 2;
  localparam int DEPTH = 8;

  logic                       clk_i  = 1'b0;
  logic                       rst_ni = 1'b0;
  logic [NR-1:0]              req_valid_i;
  logic [NR-1:0][DW-1:0]      req_data_i;
  logic [NR-1:0]              req_ready_o;
  logic                       fifo_full_i, fifo_empty_i, fifo_push_o, fifo_flush_o;
  logic [IDW+DW-1:0]          fifo_data_o;
  logic                       fifo_pop_i;
  logic [IDW-1:0]             fifo_pop_id_i;
  logic                       drain_req_i, drain_ack_o, flush_req_i, flush_ack_o;
  logic [NR-1:0][CW-1:0]      cnt_o;

  int nvec  = 0;
  int nfail = 0;

  fifo_push_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .QUOTA(Q)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o), .fifo_flush_o(fifo_flush_o),
    .fifo_pop_i(fifo_pop_i), .fifo_pop_id_i(fifo_pop_id_i),
    .drain_req_i(drain_req_i), .drain_ack_o(drain_ack_o),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .cnt_o(cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural FIFO: ID storage only.
  logic [IDW-1:0] mem [DEPTH];
  int             rd, wr, occ;
  logic           pop_en, force_full;

  assign fifo_full_i   = (occ == DEPTH) || force_full;
  assign fifo_empty_i  = (occ == 0);
  assign fifo_pop_i    = pop_en && (occ != 0);
  assign fifo_pop_id_i = mem[rd];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ <= 0; rd <= 0; wr <= 0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (fifo_flush_o) begin
      occ <= 0; rd <= 0; wr <= 0;
    end else begin
      int n;
      n = occ;
      if (fifo_pop_i) begin
        rd <= (rd + 1) % DEPTH;
        n--;
      end
      if (fifo_push_o && occ < DEPTH) begin
        mem[wr] <= fifo_data_o[DW +: IDW];
        wr <= (wr + 1) % DEPTH;
        n++;
      end
      occ <= n;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [IDW+DW-1:0] word(int id);
    return {IDW'(id), DW'(16'hC0D0 + id)};
  endfunction

  task automatic test_reset();
    req_valid_i = '0; pop_en = 1'b0; force_full = 1'b0;
    drain_req_i = 1'b0; flush_req_i = 1'b0;
    for (int i = 0; i < NR; i++) req_data_i[i] = DW'(16'hC0D0 + i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== '0) begin nfail++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
    nvec++; if (fifo_push_o !== 1'b0) begin nfail++; $display("FAIL reset_push got %b want 0", fifo_push_o); end
    nvec++; if (fifo_data_o !== '0) begin nfail++; $display("FAIL reset_data got %h want 0", fifo_data_o); end
    nvec++; if (fifo_flush_o !== 1'b0) begin nfail++; $display("FAIL reset_flush got %b want 0", fifo_flush_o); end
    nvec++; if (drain_ack_o !== 1'b0) begin nfail++; $display("FAIL reset_drain_ack got %b want 0", drain_ack_o); end
    nvec++; if (flush_ack_o !== 1'b0) begin nfail++; $display("FAIL reset_flush_ack got %b want 0", flush_ack_o); end
    nvec++; if (cnt_o !== '0) begin nfail++; $display("FAIL reset_cnt got %h want 0", cnt_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  // All valid, consumer pops every cycle: grants 0,1,2,3,0,1,2,3.
  task automatic test_round_robin();
    logic [NR-1:0] exp_rdy;
    req_valid_i = '1; pop_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = NR'(1) << (k % NR);
      @(negedge clk_i);
      nvec++; if (req_ready_o !== exp_rdy) begin nfail++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready_o, exp_rdy); end
      nvec++; if (fifo_data_o !== word(k % NR)) begin nfail++; $display("FAIL rr_data[%0d] got %h want %h", k, fifo_data_o, word(k % NR)); end
      tick();
    end
    req_valid_i = '0;
    tick();
    pop_en = 1'b0;
    @(negedge clk_i);
    nvec++; if (cnt_o !== '0) begin nfail++; $display("FAIL rr_cnt_end got %h want 0", cnt_o); end
    tick();
  endtask

  // Only requester 1 valid, no pops: two pushes then blocked by quota.
  task automatic test_quota();
    logic [NR-1:0][CW-1:0] exp_cnt;
    req_valid_i = 4'b0010; pop_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      nvec++; if (req_ready_o !== 4'b0010) begin nfail++; $display("FAIL quota_grant[%0d] got %b want 0010", k, req_ready_o); end
      tick();
    end
    exp_cnt = '0; exp_cnt[1] = 2'd2;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL quota_block got %b want 0000", req_ready_o); end
    nvec++; if (cnt_o !== exp_cnt) begin nfail++; $display("FAIL quota_cnt got %h want %h", cnt_o, exp_cnt); end
    tick();
    pop_en = 1'b1;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL quota_pop_cycle got %b want 0000", req_ready_o); end
    tick();
    pop_en = 1'b0;
    exp_cnt[1] = 2'd1;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== 4'b0010) begin nfail++; $display("FAIL quota_resume got %b want 0010", req_ready_o); end
    nvec++; if (cnt_o !== exp_cnt) begin nfail++; $display("FAIL quota_cnt_after_pop got %h want %h", cnt_o, exp_cnt); end
    tick();
    req_valid_i = '0; pop_en = 1'b1;
    tick();
    tick();
    pop_en = 1'b0;
  endtask

  // Full blocks grants regardless of quota; then fill the 8-deep FIFO.
  task automatic test_full();
    logic [NR-1:0] exp_rdy;
    req_valid_i = '1; pop_en = 1'b0; force_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      nvec++; if (req_ready_o !== '0 || fifo_push_o !== 1'b0) begin nfail++; $display("FAIL full_block[%0d] got %b/%b want 0000/0", k, req_ready_o, fifo_push_o); end
      tick();
    end
    force_full = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = NR'(1) << ((2 + k) % NR);
      @(negedge clk_i);
      nvec++; if (req_ready_o !== exp_rdy) begin nfail++; $display("FAIL fill_grant[%0d] got %b want %b", k, req_ready_o, exp_rdy); end
      tick();
    end
    @(negedge clk_i);
    nvec++; if (req_ready_o !== '0 || fifo_push_o !== 1'b0) begin nfail++; $display("FAIL fill_stop got %b/%b want 0000/0", req_ready_o, fifo_push_o); end
    nvec++; if (cnt_o !== 8'b10_10_10_10) begin nfail++; $display("FAIL fill_cnt got %h want aa", cnt_o); end
    tick();
    req_valid_i = '0; pop_en = 1'b1;
    repeat (8) tick();
    pop_en = 1'b0;
    @(negedge clk_i);
    nvec++; if (cnt_o !== '0) begin nfail++; $display("FAIL fill_drained_cnt got %h want 0", cnt_o); end
    tick();
  endtask

  // Push and pop of requester 0 in the same cycle leaves its count at 1.
  task automatic test_simultaneous();
    req_valid_i = 4'b0001; pop_en = 1'b0;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== 4'b0001) begin nfail++; $display("FAIL simul_first got %b want 0001", req_ready_o); end
    tick();
    pop_en = 1'b1;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== 4'b0001 || fifo_pop_i !== 1'b1) begin nfail++; $display("FAIL simul_both got %b/%b want 0001/1", req_ready_o, fifo_pop_i); end
    tick();
    req_valid_i = '0; pop_en = 1'b0;
    @(negedge clk_i);
    nvec++; if (cnt_o !== 8'b00_00_00_01) begin nfail++; $display("FAIL simul_cnt got %h want 01", cnt_o); end
    tick();
    pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
  endtask

  // Queue IDs 1,3,0 (rr ends at 1), drain, then resume from requester 1.
  task automatic test_drain();
    logic [NR-1:0] exp_seq [3];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0001;
    req_valid_i = 4'b1011; pop_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      nvec++; if (req_ready_o !== exp_seq[k]) begin nfail++; $display("FAIL drain_fill[%0d] got %b want %b", k, req_ready_o, exp_seq[k]); end
      tick();
    end
    req_valid_i = '0; drain_req_i = 1'b1;
    tick();
    drain_req_i = 1'b0; req_valid_i = '1; pop_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      nvec++; if (req_ready_o !== '0 || drain_ack_o !== 1'b0) begin nfail++; $display("FAIL drain_wait[%0d] got %b/%b want 0000/0", k, req_ready_o, drain_ack_o); end
      tick();
    end
    @(negedge clk_i);
    nvec++; if (drain_ack_o !== 1'b1 || req_ready_o !== '0) begin nfail++; $display("FAIL drain_ack got %b/%b want 1/0000", drain_ack_o, req_ready_o); end
    tick();
    pop_en = 1'b0;
    @(negedge clk_i);
    nvec++; if (drain_ack_o !== 1'b0) begin nfail++; $display("FAIL drain_ack_pulse got %b want 0", drain_ack_o); end
    nvec++; if (req_ready_o !== 4'b0010 || fifo_data_o !== word(1)) begin nfail++; $display("FAIL drain_resume got %b/%h want 0010/%h", req_ready_o, fifo_data_o, word(1)); end
    tick();
    req_valid_i = '0;
  endtask

  // Five entries queued, drain started, then flush aborts it.
  task automatic test_flush();
    logic [NR-1:0] exp_rdy;
    req_valid_i = '1; pop_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = NR'(1) << ((2 + k) % NR);
      @(negedge clk_i);
      nvec++; if (req_ready_o !== exp_rdy) begin nfail++; $display("FAIL flush_fill[%0d] got %b want %b", k, req_ready_o, exp_rdy); end
      tick();
    end
    req_valid_i = '0; drain_req_i = 1'b1;
    tick();
    drain_req_i = 1'b0; flush_req_i = 1'b1; req_valid_i = '1;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== '0 || drain_ack_o !== 1'b0 || fifo_flush_o !== 1'b0) begin nfail++; $display("FAIL flush_in_drain got %b/%b/%b want 0000/0/0", req_ready_o, drain_ack_o, fifo_flush_o); end
    tick();
    flush_req_i = 1'b0;
    @(negedge clk_i);
    nvec++; if (fifo_flush_o !== 1'b1 || flush_ack_o !== 1'b1) begin nfail++; $display("FAIL flush_cycle got %b/%b want 1/1", fifo_flush_o, flush_ack_o); end
    nvec++; if (req_ready_o !== '0 || drain_ack_o !== 1'b0) begin nfail++; $display("FAIL flush_no_grant got %b/%b want 0000/0", req_ready_o, drain_ack_o); end
    tick();
    @(negedge clk_i);
    nvec++; if (fifo_flush_o !== 1'b0 || flush_ack_o !== 1'b0 || drain_ack_o !== 1'b0) begin nfail++; $display("FAIL flush_exit got %b/%b/%b want 0/0/0", fifo_flush_o, flush_ack_o, drain_ack_o); end
    nvec++; if (cnt_o !== '0) begin nfail++; $display("FAIL flush_cnt got %h want 0", cnt_o); end
    nvec++; if (req_ready_o !== 4'b0001) begin nfail++; $display("FAIL flush_rr got %b want 0001", req_ready_o); end
    req_valid_i = '0;
    tick();
  endtask

  // Asynchronous reset in the middle of a FLUSH cycle.
  task automatic test_reset_in_flush();
    flush_req_i = 1'b1; req_valid_i = '0;
    tick();
    @(negedge clk_i);
    nvec++; if (fifo_flush_o !== 1'b1) begin nfail++; $display("FAIL rstflush_enter got %b want 1", fifo_flush_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    nvec++; if (fifo_flush_o !== 1'b0 || flush_ack_o !== 1'b0 || drain_ack_o !== 1'b0) begin nfail++; $display("FAIL rstflush_ctl got %b/%b/%b want 0/0/0", fifo_flush_o, flush_ack_o, drain_ack_o); end
    nvec++; if (req_ready_o !== '0 || fifo_push_o !== 1'b0 || fifo_data_o !== '0 || cnt_o !== '0) begin nfail++; $display("FAIL rstflush_data got %b/%b/%h/%h want 0", req_ready_o, fifo_push_o, fifo_data_o, cnt_o); end
    flush_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    req_valid_i = '1;
    @(negedge clk_i);
    nvec++; if (req_ready_o !== 4'b0001 || fifo_flush_o !== 1'b0) begin nfail++; $display("FAIL rstflush_run got %b/%b want 0001/0", req_ready_o, fifo_flush_o); end
    req_valid_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_quota();
    test_full();
    test_simultaneous();
    test_drain();
    test_flush();
    test_reset_in_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
